// File: rtl/midi_voice_alloc.sv
// ---------------------------------------------------------------------------
// midi_voice_alloc
//
// Polyphonic voice allocator between the UART MIDI receiver and the
// oscillator bank. Each accepted 3-byte channel message is decoded once.
// A note message then walks the voice table one slot per cycle (SCAN).
// The result is applied in a single COMMIT cycle. Omni mode: the channel
// nibble is ignored.
//
// Note-on priority: retrigger a matching active voice, else take the lowest
// free voice, else steal the oldest voice (VOICE_STEAL_EN) or drop the note.
// Note-off releases the lowest-index matching active voice.
//
// Build option:
//   VOICE_STEAL_EN - when defined, a full table steals the oldest voice.
//                    When undefined, the note is dropped with a dropped_out
//                    pulse, and the per-voice age logic is not built.
//
// Parameters:
//   NUM_VOICES  number of voice slots (2..16)
//   AGE_W       width of the per-voice age counter
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous, active-high reset
//   msg_valid_in      msg_in holds a complete message
//   msg_in            [23:16] status, [15:8] note, [7:0] velocity
//   msg_ready_out     high while idle; a message transfers on valid && ready
//   voice_active_out  bit i high while voice i holds a note
//   voice_note_out    voice i note in [7i+6:7i]
//   voice_vel_out     voice i velocity, same packing
//   voice_trig_out    one-cycle pulse when voice i is (re)assigned
//   dropped_out       one-cycle pulse when a note-on is discarded
// ---------------------------------------------------------------------------
module midi_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      msg_valid_in,
    input  logic [23:0]               msg_in,
    output logic                      msg_ready_out,
    output logic [NUM_VOICES-1:0]     voice_active_out,
    output logic [7*NUM_VOICES-1:0]   voice_note_out,
    output logic [7*NUM_VOICES-1:0]   voice_vel_out,
    output logic [NUM_VOICES-1:0]     voice_trig_out,
    output logic                      dropped_out
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    state_t                 state;

    // Voice table
    logic [NUM_VOICES-1:0]  active;
    logic [NUM_VOICES-1:0]  trig;
    logic [6:0]             note [NUM_VOICES];
    logic [6:0]             vel  [NUM_VOICES];
    logic                   dropped;

    // Latched message
    logic                   op_on;
    logic [6:0]             op_note;
    logic [6:0]             op_vel;

    // Scan results
    logic [IDX_W-1:0]       scan_idx;
    logic                   match_found;
    logic [IDX_W-1:0]       match_idx;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]       age [NUM_VOICES];
    logic                   old_found;
    logic [IDX_W-1:0]       old_idx;
    logic [AGE_W-1:0]       old_age;
`else
    // Ages have no function without stealing.
    logic [AGE_W-1:0]       unused_age;
    assign unused_age = '0;
`endif

    // Decode of the incoming message. Bit 7 of each data byte is ignored.
    logic       is_note_on;
    logic       is_note_off;
    logic       unused_msg_bits;

    assign is_note_on  = (msg_in[23:20] == 4'h9) && (msg_in[6:0] != 7'd0);
    assign is_note_off = (msg_in[23:20] == 4'h8) ||
                         ((msg_in[23:20] == 4'h9) && (msg_in[6:0] == 7'd0));
    assign unused_msg_bits = ^{msg_in[19:16], msg_in[15], msg_in[7]};

    // Commit target chosen from the scan results.
    logic             hit;
    logic [IDX_W-1:0] tgt;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hit = 1'b0;
        tgt = '0;
        if (op_on) begin
            if (match_found) begin
                hit = 1'b1;
                tgt = match_idx;
            end else if (free_found) begin
                hit = 1'b1;
                tgt = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                hit = 1'b1;
                tgt = old_idx;
`else
                hit = 1'b0;
`endif
            end
        end else begin
            hit = match_found;
            tgt = match_idx;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            active      <= '0;
            trig        <= '0;
            dropped     <= 1'b0;
            op_on       <= 1'b0;
            op_note     <= '0;
            op_vel      <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            // NOTE: the voice table is reset explicitly because its note and
            // velocity values are visible outputs, not scratch storage.
            for (int i = 0; i < NUM_VOICES; i++) begin
                note[i] <= '0;
                vel[i]  <= '0;
            end
`ifdef VOICE_STEAL_EN
            old_found   <= 1'b0;
            old_idx     <= '0;
            old_age     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age[i] <= '0;
            end
`endif
        end else begin
            trig    <= '0;
            dropped <= 1'b0;

            case (state)
                IDLE: begin
                    // Messages that are not note messages are consumed here
                    // without leaving IDLE.
                    if (msg_valid_in && (is_note_on || is_note_off)) begin
                        op_on       <= is_note_on;
                        op_note     <= msg_in[14:8];
                        op_vel      <= msg_in[6:0];
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
`ifdef VOICE_STEAL_EN
                        old_found   <= 1'b0;
`endif
                        state       <= SCAN;
                    end
                end

                SCAN: begin
                    if (active[scan_idx] && (note[scan_idx] == op_note) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!active[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
`ifdef VOICE_STEAL_EN
                    // A strict compare keeps the lowest index on equal ages.
                    if (active[scan_idx] && (!old_found || (age[scan_idx] > old_age))) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                        old_age   <= age[scan_idx];
                    end
`endif
                    if (scan_idx == IDX_W'(NUM_VOICES - 1)) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end

                COMMIT: begin
                    state <= IDLE;
                    if (op_on) begin
                        if (hit) begin
                            active[tgt] <= 1'b1;
                            note[tgt]   <= op_note;
                            vel[tgt]    <= op_vel;
                            trig[tgt]   <= 1'b1;
`ifdef VOICE_STEAL_EN
                            // The target restarts at 0; every other active
                            // voice ages by one, saturating.
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == tgt) begin
                                    age[i] <= '0;
                                end else if (active[i] && (age[i] != '1)) begin
                                    age[i] <= age[i] + 1'b1;
                                end
                            end
`endif
                        end else begin
                            dropped <= 1'b1;
                        end
                    end else if (hit) begin
                        // Note and velocity are kept for the release phase.
                        active[tgt] <= 1'b0;
`ifdef VOICE_STEAL_EN
                        age[tgt]    <= '0;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign msg_ready_out    = (state == IDLE);
    assign voice_active_out = active;
    assign voice_trig_out   = trig;
    assign dropped_out      = dropped;

    always_comb begin
        voice_note_out = '0;
        voice_vel_out  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note_out[7*i +: 7] = note[i];
            voice_vel_out[7*i +: 7]  = vel[i];
        end
    end

endmodule
